// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide engine.
//   state_t    : sequencer FSM encoding
//   OP_*       : op encodings (op[0] selects div, op[1] selects unsigned)
//   ctrl_to_op : maps the main Control's MultControl/DivControl/unsigned
//                decode onto the op bus
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_MRUN  = 3'd2,
    ST_DRUN  = 3'd3,
    ST_FIXUP = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_DIV   = 2'b01;
  localparam logic [1:0] OP_MULTU = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int OP_DIV_BIT = 0;
  localparam int OP_UNS_BIT = 1;

  // DivControl selects the divider; when it is low the op is a multiply
  // (MultControl), so only the divide and unsigned decodes reach the bus.
  function automatic logic [1:0] ctrl_to_op(input logic div_ctrl,
                                            input logic unsigned_ctrl);
    return {unsigned_ctrl, div_ctrl};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
//   is_div  : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_in  : 2W working register; mult {partial, multiplier},
//             div {remainder, dividend/quotient}
//   opnd    : multiplicand (mult) or divisor (div) magnitude
//   acc_out : working register after this iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] shifted_top;
  logic [WIDTH:0] trial;

  always_comb begin
    // Upper half plus the multiplicand when the current multiplier bit is
    // set; the carry lands in the top bit before shifting right.
    add_sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} +
                  (acc_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Remainder shifted left with the next dividend bit brought in.
    shifted_top = acc_in[2*WIDTH-1:WIDTH-1];
    trial       = shifted_top - {1'b0, opnd};
    if (is_div) begin
      if (!trial[WIDTH]) begin
        acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {shifted_top[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_out = {add_sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine with the architectural Hi/Lo registers.
//   clk, reset          : clock, synchronous active-high reset
//   start, op           : launch request (sampled in IDLE) and op select
//   operand_a/operand_b : rs / rt, latched when start is accepted
//   busy                : high in every state except IDLE
//   done                : one-cycle pulse when Hi/Lo valid or div-by-zero
//   div_zero            : one-cycle pulse with done when divisor is zero
//   hi, lo              : Hi/Lo registers
//
// state | meaning
// IDLE  | waiting for start
// PREP  | take magnitudes, record result signs, detect divide by zero
// MRUN  | WIDTH shift-add multiply iterations
// DRUN  | WIDTH restoring divide iterations
// FIXUP | apply result signs, write Hi/Lo on exit
// DONE  | done pulse, back to IDLE
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] step_out;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_q[OP_DIV_BIT]),
    .acc_in  (acc_q),
    .opnd    (opnd_q),
    .acc_out (step_out)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;

    // Unsigned ops never negate, so FIXUP degenerates to a pass-through.
    a_neg = !op_q[OP_UNS_BIT] && a_q[WIDTH-1];
    b_neg = !op_q[OP_UNS_BIT] && b_q[WIDTH-1];
    mag_a = a_neg ? -a_q : a_q;
    mag_b = b_neg ? -b_q : b_q;
    prod  = neg_lo_q ? -acc_q : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = operand_a;
          b_d     = operand_b;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        if (op_q[OP_DIV_BIT] && (b_q == '0)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          dz_d    = 1'b1;
        end else begin
          cnt_d    = CW'(WIDTH - 1);
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = op_q[OP_DIV_BIT] ? a_neg : (a_neg ^ b_neg);
          if (op_q[OP_DIV_BIT]) begin
            opnd_d  = mag_b;
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            state_d = ST_DRUN;
          end else begin
            opnd_d  = mag_a;
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            state_d = ST_MRUN;
          end
        end
      end
      ST_MRUN, ST_DRUN: begin
        acc_d = step_out;
        if (cnt_q == '0) begin
          state_d = ST_FIXUP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_FIXUP: begin
        if (op_q[OP_DIV_BIT]) begin
          lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          lo_d = prod[WIDTH-1:0];
          hi_d = prod[2*WIDTH-1:WIDTH];
        end
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sbv, q, r;
    logic        [63:0] res;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    case (mop)
      OP_MULT:  res = sa * sbv;
      OP_MULTU: res = {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        q   = sa / sbv;
        r   = sa % sbv;
        res = {r[31:0], q[31:0]};
      end
      default:  res = {a % b, a / b};
    endcase
    return res;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz, input int inj);
    exp_t e, got;
    bit   seen;
    e.hi  = exp_hi;
    e.lo  = exp_lo;
    e.dz  = exp_dz;
    e.lat = exp_dz ? 2 : W + 3;
    sb.push_back(e);
    @(posedge clk); #1;
    op = op_i; operand_a = a_i; operand_b = b_i; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = $urandom; operand_b = $urandom; op = 2'($urandom_range(0, 3));
    seen = 0;
    for (int n = 1; n <= 100 && !seen; n++) begin
      @(negedge clk);
      start = (n == inj);
      if (n == inj) op = ~op_i;
      if (n == 1) chk({tag, "_busy"}, busy, 1);
      if (n == e.lat - 1) begin
        chk({tag, "_hold_hi"}, hi, last_hi);
        chk({tag, "_hold_lo"}, lo, last_lo);
      end
      if (done) begin
        seen = 1;
        got  = sb.pop_front();
        chk({tag, "_latency"}, n, got.lat);
        chk({tag, "_hi"}, hi, got.hi);
        chk({tag, "_lo"}, lo, got.lo);
        chk({tag, "_div_zero"}, div_zero, got.dz);
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_pulse"}, done, 0);
    if (!exp_dz) begin
      last_hi = exp_hi;
      last_lo = exp_lo;
    end
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] m;
    int          done_cnt;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset = 1'b0;

    run_op("mult_neg", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
    run_op("mult_m1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 0, 0);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0);
    run_op("divu_setup", OP_DIVU, 32'h2211, 32'h100, 32'h11, 32'h22, 0, 0);
    run_op("div_zero", OP_DIV, 32'd5, 32'd0, 32'h11, 32'h22, 1, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 0);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 2 == 1) rb = rb >> $urandom_range(0, 31);
      if (rb == 0) rb = 32'd1;
      m = model(rop, ra, rb);
      run_op("rand", rop, ra, rb, m[63:32], m[31:0], 0, 0);
    end

    run_op("mult_ignore_start", OP_MULT, 32'h1234, 32'h5678, 32'h0, 32'h0626_0060, 0, 6);

    // Reset in the middle of a divide aborts it completely.
    @(posedge clk); #1;
    op = OP_DIV; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 11; n++) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_done", done, 0);
    reset = 1'b0;
    last_hi = '0;
    last_lo = '0;
    done_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
